// File: rtl/duck_hunt_pkg.sv
// Shared types and screen constants for the Duck Hunt game logic.
package duck_hunt_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, COOLDOWN, EMPTY} shot_state_t;

    localparam int unsigned SCREEN_H_MAX = 1023;
    localparam int unsigned SCREEN_V_MAX = 767;
    localparam int unsigned POS_W        = 12;

    // Unsigned saturation of a coordinate to the visible range.
    function automatic logic [POS_W-1:0] clamp_coord(input logic [POS_W-1:0] v,
                                                     input logic [POS_W-1:0] vmax);
        return (v > vmax) ? vmax : v;
    endfunction

endpackage

// File: rtl/btn_edge_det.sv
// Registers a synchronous button level and emits a one-cycle rising-edge pulse.
module btn_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic rise_o
);

    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/mouse_shot_ctl.sv
// Turns mouse clicks into clamped, ammo-limited shot events with a per-shot cooldown,
// handed to hit detection over a valid/ready handshake.
module mouse_shot_ctl
    import duck_hunt_pkg::*;
#(
    parameter int unsigned H_MAX           = SCREEN_H_MAX,
    parameter int unsigned V_MAX           = SCREEN_V_MAX,
    parameter int unsigned COOLDOWN_CYCLES = 6_500_000,
    parameter int unsigned AMMO            = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] xpos_bf1,
    input  logic [11:0] ypos_bf1,
    input  logic        left,
    input  logic        round_start,
    input  logic        shot_ready,
    output logic        shot_valid,
    output logic [11:0] shot_x,
    output logic [11:0] shot_y,
    output logic [1:0]  ammo,
    output logic        busy
);

    localparam int unsigned    CntW     = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(COOLDOWN_CYCLES - 1);
    localparam logic [11:0]    HMax     = 12'(H_MAX);
    localparam logic [11:0]    VMax     = 12'(V_MAX);
    localparam logic [1:0]     AmmoInit = 2'(AMMO);

    shot_state_t     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      ammo_q, ammo_d;
    logic [11:0]     x_q, x_d;
    logic [11:0]     y_q, y_d;
    logic            click;

    btn_edge_det u_btn_edge_det (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (left),
        .rise_o  (click)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ammo_d  = ammo_q;
        x_d     = x_q;
        y_d     = y_q;
        // Round start overrides everything, including a coincident click or pending shot.
        if (round_start) begin
            state_d = IDLE;
            ammo_d  = AmmoInit;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (click && (ammo_q != 2'd0)) begin
                        x_d     = clamp_coord(xpos_bf1, HMax);
                        y_d     = clamp_coord(ypos_bf1, VMax);
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (shot_ready) begin
                        ammo_d = ammo_q - 2'd1;
                        if (ammo_q == 2'd1) begin
                            state_d = EMPTY;
                        end else begin
                            cnt_d   = CntLoad;
                            state_d = COOLDOWN;
                        end
                    end
                end
                COOLDOWN: begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                EMPTY: begin
                    state_d = EMPTY;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ammo_q  <= AmmoInit;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ammo_q  <= ammo_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign shot_valid = (state_q == HOLD);
    assign busy       = (state_q == HOLD) || (state_q == COOLDOWN);
    assign shot_x     = x_q;
    assign shot_y     = y_q;
    assign ammo       = ammo_q;

endmodule

// File: tb/tb_mouse_shot_ctl.sv
// Scoreboard bench for mouse_shot_ctl: expected shots are queued by the stimulus and
// popped by a monitor on every handshake transfer; state outputs are checked inline.
module tb_mouse_shot_ctl;

    logic        clk;
    logic        rst_n;
    logic [11:0] xpos_bf1;
    logic [11:0] ypos_bf1;
    logic        left;
    logic        round_start;
    logic        shot_ready;
    logic        shot_valid;
    logic [11:0] shot_x;
    logic [11:0] shot_y;
    logic [1:0]  ammo;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [23:0] exp_q[$];

    mouse_shot_ctl #(
        .H_MAX           (1023),
        .V_MAX           (767),
        .COOLDOWN_CYCLES (4),
        .AMMO            (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .xpos_bf1    (xpos_bf1),
        .ypos_bf1    (ypos_bf1),
        .left        (left),
        .round_start (round_start),
        .shot_ready  (shot_ready),
        .shot_valid  (shot_valid),
        .shot_x      (shot_x),
        .shot_y      (shot_y),
        .ammo        (ammo),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every transfer must match the oldest expected shot.
    always @(negedge clk) begin
        if (rst_n && shot_valid && shot_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_shot", 1, 0);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                check("shot_x", int'(shot_x), int'(e[23:12]));
                check("shot_y", int'(shot_y), int'(e[11:0]));
            end
        end
    end

    // Click, expect HOLD next cycle, transfer with ready high, then wait out the cooldown.
    task automatic fire(input logic [11:0] x, input logic [11:0] y,
                        input logic [11:0] ex, input logic [11:0] ey);
        xpos_bf1 = x;
        ypos_bf1 = y;
        left     = 1'b1;
        exp_q.push_back({ex, ey});
        step();
        check("fire_valid", int'(shot_valid), 1);
        step();
        left = 1'b0;
        repeat (6) step();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int valid_seen;
        rst_n       = 1'b0;
        xpos_bf1    = '0;
        ypos_bf1    = '0;
        left        = 1'b0;
        round_start = 1'b0;
        shot_ready  = 1'b1;
        #12;
        check("rst_valid", int'(shot_valid), 0);
        check("rst_x", int'(shot_x), 0);
        check("rst_y", int'(shot_y), 0);
        check("rst_ammo", int'(ammo), 3);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (2) step();

        // Basic shot, held button, cooldown length.
        xpos_bf1 = 12'd100;
        ypos_bf1 = 12'd200;
        left     = 1'b1;
        exp_q.push_back({12'd100, 12'd200});
        step();
        check("basic_valid", int'(shot_valid), 1);
        check("basic_x", int'(shot_x), 100);
        check("basic_y", int'(shot_y), 200);
        step();
        check("basic_ammo", int'(ammo), 2);
        check("basic_valid_after", int'(shot_valid), 0);
        busy_cnt   = int'(busy);
        valid_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy && !shot_valid) busy_cnt++;
            if (shot_valid) valid_seen++;
        end
        check("basic_cooldown_len", busy_cnt, 4);
        check("basic_held_no_refire", valid_seen, 0);
        left = 1'b0;
        step();

        // Clamp.
        fire(12'd1500, 12'd4095, 12'd1023, 12'd767);
        check("clamp_ammo", int'(ammo), 1);
        round_start = 1'b1;
        step();
        round_start = 1'b0;
        check("reload_ammo", int'(ammo), 3);
        fire(12'd1023, 12'd767, 12'd1023, 12'd767);
        check("edge_ammo", int'(ammo), 2);

        // Backpressure: held shot, mouse moves, second click dropped.
        shot_ready = 1'b0;
        xpos_bf1   = 12'd50;
        ypos_bf1   = 12'd60;
        left       = 1'b1;
        exp_q.push_back({12'd50, 12'd60});
        step();
        left     = 1'b0;
        xpos_bf1 = 12'd10;
        ypos_bf1 = 12'd10;
        for (int i = 0; i < 4; i++) begin
            left = (i == 1);
            step();
            check("bp_valid_hold", int'(shot_valid), 1);
            check("bp_x_hold", int'(shot_x), 50);
            check("bp_y_hold", int'(shot_y), 60);
        end
        left       = 1'b0;
        shot_ready = 1'b1;
        step();
        check("bp_ammo", int'(ammo), 1);
        check("bp_valid_drop", int'(shot_valid), 0);
        valid_seen = 0;
        repeat (6) begin
            step();
            if (shot_valid) valid_seen++;
        end
        check("bp_second_dropped", valid_seen, 0);

        // Cooldown click ignored, ammo runs out, EMPTY ignores clicks.
        round_start = 1'b1;
        step();
        round_start = 1'b0;
        xpos_bf1 = 12'd200;
        ypos_bf1 = 12'd300;
        left     = 1'b1;
        exp_q.push_back({12'd200, 12'd300});
        step();
        step();
        left = 1'b0;
        step();
        left = 1'b1;
        step();
        left = 1'b0;
        check("cd_click_ignored", int'(shot_valid), 0);
        repeat (4) step();
        check("cd_done_busy", int'(busy), 0);
        check("cd_ammo2", int'(ammo), 2);
        fire(12'd300, 12'd400, 12'd300, 12'd400);
        check("cd_ammo1", int'(ammo), 1);
        fire(12'd5, 12'd6, 12'd5, 12'd6);
        check("cd_ammo0", int'(ammo), 0);
        check("empty_busy", int'(busy), 0);
        left = 1'b1;
        valid_seen = 0;
        repeat (4) begin
            step();
            if (shot_valid) valid_seen++;
        end
        left = 1'b0;
        check("empty_no_shot", valid_seen, 0);
        check("empty_ammo", int'(ammo), 0);

        // Round start aborts a pending shot; coincident click is ignored.
        round_start = 1'b1;
        step();
        round_start = 1'b0;
        shot_ready  = 1'b0;
        xpos_bf1 = 12'd400;
        ypos_bf1 = 12'd400;
        left     = 1'b1;
        step();
        check("rs_hold_valid", int'(shot_valid), 1);
        left        = 1'b0;
        round_start = 1'b1;
        step();
        round_start = 1'b0;
        check("rs_abort_valid", int'(shot_valid), 0);
        check("rs_abort_ammo", int'(ammo), 3);
        shot_ready = 1'b1;
        step();
        left        = 1'b1;
        round_start = 1'b1;
        step();
        round_start = 1'b0;
        check("rs_coinc_valid", int'(shot_valid), 0);
        check("rs_coinc_ammo", int'(ammo), 3);
        step();
        check("rs_coinc_no_late", int'(shot_valid), 0);
        left = 1'b0;
        step();

        // Async reset mid-cooldown.
        xpos_bf1 = 12'd77;
        ypos_bf1 = 12'd88;
        left     = 1'b1;
        exp_q.push_back({12'd77, 12'd88});
        step();
        step();
        left = 1'b0;
        check("ar_busy_before", int'(busy), 1);
        check("ar_ammo_before", int'(ammo), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", int'(shot_valid), 0);
        check("ar_x", int'(shot_x), 0);
        check("ar_y", int'(shot_y), 0);
        check("ar_ammo", int'(ammo), 3);
        check("ar_busy", int'(busy), 0);
        #4;
        rst_n = 1'b1;
        step();
        fire(12'd7, 12'd8, 12'd7, 12'd8);
        check("ar_after_ammo", int'(ammo), 2);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mouse_shot_ctl.md
# mouse_shot_ctl

Converts the double-registered mouse position and the left-button level into discrete, ammo-limited shot events for the Duck Hunt game logic. It sits directly downstream of the mouse position buffer stage. It consumes `xpos_bf1`/`ypos_bf1` and `left`, and hands each shot (clamped coordinates) to the hit-detection logic over a valid/ready handshake. It enforces a per-shot cooldown and an ammo count that is reloaded at each round start.

## Interface
Parameters:
- `H_MAX`, 1023, largest legal shot x coordinate (visible width − 1).
- `V_MAX`, 767, largest legal shot y coordinate (visible height − 1).
- `COOLDOWN_CYCLES`, 6_500_000, number of cycles the block stays unarmed after an accepted shot (100 ms at 65 MHz). Must be ≥ 1.
- `AMMO`, 3, shots available per round. Range 1..3.

Ports:
- `clk`  in  1  system (pixel) clock.
- `rst_n`  in  1  reset. One clock domain; reset is asynchronous and active-low.
- `xpos_bf1`  in  12  buffered mouse x.
- `ypos_bf1`  in  12  buffered mouse y.
- `left`  in  1  left-button level, already synchronous to `clk`.
- `round_start`  in  1  one-cycle pulse; reloads ammo and aborts any activity.
- `shot_ready`  in  1  consumer accepts the shot.
- `shot_valid`  out  1  a shot is pending.
- `shot_x`  out  12  clamped x of the pending shot.
- `shot_y`  out  12  clamped y of the pending shot.
- `ammo`  out  2  remaining shots.
- `busy`  out  1  high in HOLD or COOLDOWN.

## Operation
- Edge detect: `left_d` registers `left`. A click is `left & ~left_d`. Only rising edges fire; a held button never re-fires.
- States:
  - IDLE (armed): on a click with `ammo > 0`, capture the clamped coordinates and go to HOLD.
  - HOLD: `shot_valid` is high, and `shot_x`/`shot_y` are stable. On `shot_valid & shot_ready`, decrement `ammo`. If the pre-decrement ammo was 1, go to EMPTY; otherwise load the counter and go to COOLDOWN.
  - COOLDOWN: the counter is loaded with COOLDOWN_CYCLES−1 and decrements each cycle. Leave for IDLE in the cycle after the counter reads 0, so the block spends exactly COOLDOWN_CYCLES cycles in COOLDOWN.
  - EMPTY: clicks are ignored. Leave only via `round_start`.
- Clamp rule: `shot_x = (xpos_bf1 > H_MAX) ? H_MAX : xpos_bf1`, using an unsigned compare. `shot_y` uses the same rule with `V_MAX`.
- Clicks in HOLD, COOLDOWN or EMPTY are dropped, not queued.
- `round_start` has priority over everything in the same cycle:
  - `ammo` is set to AMMO and the state goes to IDLE.
  - A pending shot is discarded: `shot_valid` falls the next cycle. This is the only case in which valid drops without ready.
  - A click coincident with `round_start` is ignored.
  - `left_d` still updates.
- Cooldown counter width is `$clog2(COOLDOWN_CYCLES+1)`. The counter never wraps.

## Timing
- Reset values:
  - `shot_valid` = 0
  - `shot_x` = 0
  - `shot_y` = 0
  - `ammo` = AMMO
  - `busy` = 0
  - state = IDLE
  - `left_d` = 0
  - counter = 0
- Latency: a click seen in cycle N produces `shot_valid` = 1 from cycle N+1, with coordinates sampled in cycle N.
- Handshake: a transfer occurs in any cycle with valid & ready, including the first valid cycle. Valid, x and y hold until transfer.
- Decrement timing: `ammo` updates in the cycle after transfer. In that same cycle the state is COOLDOWN or EMPTY.
- Re-arm: the earliest next shot is a click in cycle T+1+COOLDOWN_CYCLES, where T is the transfer cycle.
- Reset assertion mid-operation returns all registers immediately to their reset values.

## Structure
- Shared package `duck_hunt_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, HOLD, COOLDOWN, EMPTY} shot_state_t`
  - default constants `SCREEN_H_MAX` and `SCREEN_V_MAX`, which feed the `H_MAX`/`V_MAX` defaults.
- One sub-module, `btn_edge_det`: registers the button level and outputs the rising-edge pulse (reset to 0).
- The FSM, counter, ammo register and clamp logic live in the top module.

## Test plan
Bench parameters: COOLDOWN_CYCLES=4, AMMO=3, `shot_ready` tied high unless stated otherwise.
- **Basic shot:** x=100, y=200, `left` rises in cycle N → `shot_valid` high in N+1 with (100,200); `ammo` reads 2 in N+2; `busy` high for 4 cycles; `left` held high for 20 cycles gives no second shot.
- **Clamp:** x=1500, y=4095 → shot (1023,767); x=1023, y=767 → unchanged.
- **Backpressure:** `shot_ready`=0 for 5 cycles while the mouse moves to (10,10) → valid stays high with the original coordinates; second click is dropped; transfer on the first ready cycle.
- **Cooldown and empty:** click during cooldown is ignored; three spaced clicks → `ammo` goes 3→2→1→0 and state reaches EMPTY; a fourth click produces no valid.
- **Round start:** `round_start` during HOLD → valid low next cycle, `ammo`=3; `round_start` coincident with a click → no shot, `ammo`=3.
- **Async reset:** `rst_n` pulsed low mid-COOLDOWN, without a clock edge → all outputs at reset values immediately; after release, the first click fires normally.
